mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Drives `sel` for the external 2:1 multiplexers on the address and write-data paths.
- Sequences one memory transaction at a time using a req/ready handshake.
- Arbitration is round-robin by default; fixed priority is available as a compile option.

Parameters:
AW, 32, address width of both ports and of mem_addr
DW, 32, data width of wdata/rdata

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 request; held high until done0
addr0  input  AW  port 0 address
we0  input  1  port 0 write enable
wdata0  input  DW  port 0 write data
req1  input  1  port 1 request; held high until done1
addr1  input  AW  port 1 address
we1  input  1  port 1 write enable
wdata1  input  DW  port 1 write data
gnt0  output  1  one-cycle pulse: port 0 transaction accepted
gnt1  output  1  one-cycle pulse: port 1 transaction accepted
done0  output  1  one-cycle pulse: port 0 transaction complete, rdata valid
done1  output  1  one-cycle pulse: port 1 transaction complete, rdata valid
rdata  output  DW  registered read data for the completed transaction
sel  output  1  mux select for the shared path: 0 = port 0, 1 = port 1
mem_req  output  1  memory request, held until mem_ready
mem_addr  output  AW  latched address
mem_we  output  1  latched write enable
mem_wdata  output  DW  latched write data
mem_ready  input  1  memory completion strobe
mem_rdata  input  DW  memory read data, valid when mem_ready=1

Behaviour:
- Reset values (asynchronous, immediate on reset=1):
  - State IDLE.
  - gnt0/1, done0/1, mem_req, mem_we, sel = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - last_gnt = 1, so port 0 wins the first tie.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If any reqX is sampled high at a rising edge, pick a winner.
  - Only one request high: that port wins.
  - Both high: the port not equal to last_gnt wins.
  - On that same edge: sel = winner, gntW = 1 for exactly one cycle, mem_req = 1, mem_addr/mem_we/mem_wdata latch the winner's inputs, last_gnt = winner, state goes to BUSY.
  - Latency from req sampled to mem_req high: 1 cycle.
- BUSY:
  - mem_req, mem_addr, mem_we, mem_wdata and sel stay stable.
  - Requester inputs are ignored.
  - When mem_ready is sampled high:
    - rdata = mem_rdata (also captured on writes; the value is don't-care to requesters).
    - doneW = 1 for one cycle.
    - mem_req = 0.
    - State returns to IDLE.
  - sel holds its value after completion until the next grant.
- Throughput: at most one transaction per 2 cycles. Minimum req-to-done latency is 2 cycles, reached when mem_ready is high in the first BUSY cycle.
- Boundary conditions:
  - Requester drops reqX while BUSY: the transaction still completes and doneX still pulses.
  - Requester keeps reqX high in the cycle doneX pulses: this is a new request. It is arbitrated at the next edge, since the FSM is in IDLE in that cycle.
  - mem_ready high while IDLE: ignored; no done pulse, no state change.
  - gnt0 and gnt1 are never high together; likewise done0 and done1.
  - Reset asserted while BUSY: the transaction is abandoned immediately, with no done pulse. After reset release, arbitration restarts with port 0 favored.
  - No timeout: the FSM waits in BUSY indefinitely for mem_ready.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: when both ports request in IDLE, port 1 (data) always wins. last_gnt is still updated but not used for the decision. Port 0 can starve while req1 stays high.
- Undefined: round-robin as described above. Neither port can be granted twice in a row while the other is requesting.

Test Plan:
- Reset, then req0=1, addr0=0x00000100, we0=0; mem_ready=1 two cycles after mem_req rises, mem_rdata=0xDEADBEEF -> gnt0 pulses 1 cycle after req0; mem_addr=0x100 and sel=0 during BUSY; done0 pulses the cycle after mem_ready; rdata=0xDEADBEEF.
- Reset, then req0 and req1 rise together (addr0=0x10, addr1=0x20), mem_ready returned in the first BUSY cycle -> port 0 is served first (sel=0, mem_addr=0x10), then port 1 (sel=1, mem_addr=0x20); each done pulses once.
- Both requests held high for 4 transactions, macro undefined -> grant order 0,1,0,1; no adjacent duplicates; gnt0 and gnt1 never overlap.
- Write from port 1: addr1=0x40, we1=1, wdata1=0x12345678 -> mem_we=1, mem_wdata=0x12345678, mem_addr=0x40 held until mem_ready; done1 pulses once.
- Reset asserted while BUSY, before mem_ready -> mem_req=0 and sel=0 in the same cycle (asynchronous); no done pulse; after release, req1 alone is granted normally.
- ARB_FIXED_PRIORITY_EN defined, both requests held for 3 transactions -> gnt1 three times, gnt0 never; mem_ready pulses while IDLE produce no done pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports, the shared-path select and the memory
// port of mem_port_arbiter. The arbiter uses the slave view; the
// requesters/memory (or a bench) use the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          we0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          we1;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          sel;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, addr0, we0, wdata0, req1, addr1, we1, wdata1,
               mem_ready, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, sel,
               mem_req, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, addr0, we0, wdata0, req1, addr1, we1, wdata1,
               mem_ready, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, sel,
               mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// (port 0) and load/store (port 1), one transaction at a time.
// Round-robin on ties by default; define ARB_FIXED_PRIORITY_EN to make
// port 1 always win ties. All outputs are registered.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state, nxt_state;
    logic          gnt0, gnt1, done0, done1, sel, mem_req, mem_we, last_gnt;
    logic          nxt_gnt0, nxt_gnt1, nxt_done0, nxt_done1, nxt_sel;
    logic          nxt_mem_req, nxt_mem_we, nxt_last_gnt;
    logic [AW-1:0] mem_addr, nxt_mem_addr;
    logic [DW-1:0] mem_wdata, nxt_mem_wdata, rdata, nxt_rdata;
    logic          win;

    // Winner of the current request set; only meaningful when a request is up
    always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
        win = bus.req1;
`else
        win = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
`endif
    end

    // Next-state and next-output decode; registers hold by default
    always_comb begin
        nxt_state     = state;
        nxt_gnt0      = 1'b0;
        nxt_gnt1      = 1'b0;
        nxt_done0     = 1'b0;
        nxt_done1     = 1'b0;
        nxt_sel       = sel;
        nxt_mem_req   = mem_req;
        nxt_mem_we    = mem_we;
        nxt_mem_addr  = mem_addr;
        nxt_mem_wdata = mem_wdata;
        nxt_rdata     = rdata;
        nxt_last_gnt  = last_gnt;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    nxt_sel       = win;
                    nxt_gnt0      = ~win;
                    nxt_gnt1      = win;
                    nxt_mem_req   = 1'b1;
                    nxt_mem_addr  = win ? bus.addr1  : bus.addr0;
                    nxt_mem_we    = win ? bus.we1    : bus.we0;
                    nxt_mem_wdata = win ? bus.wdata1 : bus.wdata0;
                    nxt_last_gnt  = win;
                    nxt_state     = BUSY;
                end
            end
            BUSY: begin
                // Requester inputs are ignored here; sel identifies the owner
                if (bus.mem_ready) begin
                    nxt_rdata   = bus.mem_rdata;
                    nxt_done0   = ~sel;
                    nxt_done1   = sel;
                    nxt_mem_req = 1'b0;
                    nxt_state   = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State and output registers; reset abandons any open transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            sel       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            last_gnt  <= 1'b1;
        end else begin
            state     <= nxt_state;
            gnt0      <= nxt_gnt0;
            gnt1      <= nxt_gnt1;
            done0     <= nxt_done0;
            done1     <= nxt_done1;
            sel       <= nxt_sel;
            mem_req   <= nxt_mem_req;
            mem_we    <= nxt_mem_we;
            mem_addr  <= nxt_mem_addr;
            mem_wdata <= nxt_mem_wdata;
            rdata     <= nxt_rdata;
            last_gnt  <= nxt_last_gnt;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.done0     = done0;
    assign bus.done1     = done1;
    assign bus.sel       = sel;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.rdata     = rdata;

endmodule
